ps2_kbd_axil_slave: RTL and testbench

AXI4-Lite responder that terminates the control-bus accesses issued to the PS/2 keyboard debug peripheral. It holds four read/write 32-bit registers that drive the fabric, plus one read-only status word that captures the latest keyboard scan code. Reads of the status word clear it. The block sits between the interconnect master port and the PS/2 receive logic.

---
 rtl/ps2_kbd_axil_slave.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_kbd_axil_slave.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_axil_slave.sv
// AXI4-Lite register block for the PS/2 keyboard debug peripheral: four
// read/write control words plus a clear-on-read scan-code status word.
module ps2_kbd_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [7:0]                        KBD_CODE,
    input  logic                              KBD_VALID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG0_O,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG1_O,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG2_O,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG3_O
);

    localparam int         DW          = C_S_AXI_DATA_WIDTH;
    localparam int         NB          = DW / 8;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    // Write-path state
    logic            aw_held_q, aw_held_d;
    logic [2:0]      aw_idx_q,  aw_idx_d;
    logic            w_held_q,  w_held_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [NB-1:0]   wstrb_q,   wstrb_d;
    logic            bvalid_q,  bvalid_d;
    logic [DW-1:0]   regs_q [4];
    logic [DW-1:0]   regs_d [4];

    // Status word state
    logic [7:0]      stat_code_q,  stat_code_d;
    logic            stat_valid_q, stat_valid_d;
    logic            stat_ovr_q,   stat_ovr_d;

    // Read-path state
    rd_state_e       rd_state_q;
    logic            rvalid_q;
    logic [DW-1:0]   rdata_q;

    logic            aw_hs, w_hs, ar_hs, commit, stat_clr;
    logic [2:0]      wr_idx;
    logic [DW-1:0]   wr_data, wr_merged, rd_mux;
    logic [NB-1:0]   wr_strb;
    logic            unused_inputs;

    // Readies are gated by reset so they read low while ARESETN is asserted
    // and high in the very first cycle after release.
    assign S_AXI_AWREADY = ARESETN & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ARESETN & ~w_held_q  & ~bvalid_q;
    assign S_AXI_ARREADY = ARESETN & (rd_state_q == R_IDLE);
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign REG0_O        = regs_q[0];
    assign REG1_O        = regs_q[1];
    assign REG2_O        = regs_q[2];
    assign REG3_O        = regs_q[3];

    assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_idx   = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
    assign wr_data  = w_held_q  ? wdata_q  : S_AXI_WDATA;
    assign wr_strb  = w_held_q  ? wstrb_q  : S_AXI_WSTRB;
    assign stat_clr = ar_hs & (S_AXI_ARADDR[4:2] == ADDR_STATUS);

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        wr_merged = regs_q[wr_idx[1:0]];
        for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        regs_d    = regs_q;
        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (!wr_idx[2]) regs_d[wr_idx[1:0]] = wr_merged;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end
        end
    end

    // A fresh scan code in the same cycle as a clear wins and starts clean.
    always_comb begin
        stat_code_d  = stat_code_q;
        stat_valid_d = stat_valid_q;
        stat_ovr_d   = stat_ovr_q;
        if (KBD_VALID) begin
            stat_code_d  = KBD_CODE;
            stat_valid_d = 1'b1;
            stat_ovr_d   = stat_clr ? 1'b0 : (stat_ovr_q | stat_valid_q);
        end else if (stat_clr) begin
            stat_valid_d = 1'b0;
            stat_ovr_d   = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: rd_mux = regs_q[S_AXI_ARADDR[3:2]];
            ADDR_STATUS: rd_mux = {{(DW-10){1'b0}}, stat_ovr_q, stat_valid_q, stat_code_q};
            default:     rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; a same-cycle read sees the old register data.
    // The register file is reset explicitly because its value drives the fabric.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q    <= 1'b0;
            aw_idx_q     <= '0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            stat_code_q  <= '0;
            stat_valid_q <= 1'b0;
            stat_ovr_q   <= 1'b0;
        end else begin
            aw_held_q    <= aw_held_d;
            aw_idx_q     <= aw_idx_d;
            w_held_q     <= w_held_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            regs_q       <= regs_d;
            stat_code_q  <= stat_code_d;
            stat_valid_q <= stat_valid_d;
            stat_ovr_q   <= stat_ovr_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: if (S_AXI_ARVALID) begin
                    rdata_q    <= rd_mux;
                    rvalid_q   <= 1'b1;
                    rd_state_q <= R_DATA;
                end
                R_DATA: if (S_AXI_RREADY) begin
                    rvalid_q   <= 1'b0;
                    rd_state_q <= R_IDLE;
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_axil_slave.sv
// Directed bench for ps2_kbd_axil_slave: register access, byte strobes,
// split AW/W with back-pressure, status clear-on-read and async reset.
module tb_ps2_kbd_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  kbd_code;
    logic        kbd_valid;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, reg0, reg1, reg2, reg3;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ps2_kbd_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .KBD_CODE(kbd_code), .KBD_VALID(kbd_valid),
        .REG0_O(reg0), .REG1_O(reg1), .REG2_O(reg2), .REG3_O(reg3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        check("wr_accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("bvalid_timeout", 32'(n < 20), 32'd1);
        resp = bresp;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("ar_accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("rvalid_timeout", 32'(n < 20), 32'd1);
        d = rdata; resp = rresp;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_regs [4];

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; bready = 0;
        arvalid = 0; rready = 0; wdata = '0; wstrb = '0; kbd_code = '0; kbd_valid = 0;

        // Reset state
        #2;
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

        // Basic write / readback
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
            check("bresp", 32'(r), 32'd0);
        end
        exp_regs[0] = 32'd1; exp_regs[1] = 32'd2; exp_regs[2] = 32'd3; exp_regs[3] = 32'd4;
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r);
            check("readback", d, exp_regs[i]);
            check("rresp", 32'(r), 32'd0);
        end
        check("reg0_o", reg0, 32'd1);
        check("reg1_o", reg1, 32'd2);
        check("reg2_o", reg2, 32'd3);
        check("reg3_o", reg3, 32'd4);

        // Byte strobes
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, r);
        axi_write(5'h04, 32'h1234_5678, 4'b0101, r);
        axi_read(5'h04, d, r);
        check("wstrb_0101", d, 32'hFF34_FF78);

        // Unmapped and STATUS writes are discarded with OKAY
        axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF, r);
        check("unmapped_bresp", 32'(r), 32'd0);
        axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, r);
        check("status_wr_regs", reg0 ^ reg1 ^ reg2 ^ reg3, 32'h1 ^ 32'hFF34_FF78 ^ 32'h3 ^ 32'h4);
        axi_read(5'h14, d, r);
        check("unmapped_rd", d, 32'd0);
        axi_read(5'h10, d, r);
        check("status_after_wr", d, 32'd0);

        // W two cycles ahead of AW, BREADY held low
        @(negedge clk);
        wdata = 32'hAABB_CCDD; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_held_wready", {30'd0, wready, awready}, 32'b01);
        @(negedge clk);
        check("w_held_wait", {30'd0, wready, bvalid}, 32'b00);
        awaddr = 5'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("split_commit", {29'd0, bvalid, awready, wready}, 32'b100);
        check("split_reg2", reg2, 32'hAABB_CCDD);
        awaddr = 5'h0C; awvalid = 1'b1; wdata = 32'h1111_1111; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {29'd0, bvalid, awready, wready}, 32'b100);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_reg3", reg3, 32'd4);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bp_release", {29'd0, bvalid, awready, wready}, 32'b011);

        // Scan-code capture, overrun, clear-on-read
        @(negedge clk); kbd_code = 8'h1C; kbd_valid = 1'b1;
        @(negedge clk); kbd_code = 8'h32;
        @(negedge clk); kbd_valid = 1'b0;
        axi_read(5'h10, d, r);
        check("status_first", d, 32'h0000_0332);
        axi_read(5'h10, d, r);
        check("status_second", d, 32'h0000_0032);

        // Clear coinciding with a new code
        @(negedge clk); kbd_code = 8'h55; kbd_valid = 1'b1;
        @(negedge clk); kbd_valid = 1'b0;
        araddr = 5'h10; arvalid = 1'b1; rready = 1'b1; kbd_code = 8'h66; kbd_valid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; kbd_valid = 1'b0;
        check("clr_race_rdata", {31'd0, rvalid}, 32'd1);
        check("clr_race_value", rdata, 32'h0000_0155);
        @(negedge clk);
        rready = 1'b0;
        axi_read(5'h10, d, r);
        check("clr_race_after", d, 32'h0000_0166);

        // Reset with a write response and a read response both pending
        @(negedge clk);
        awaddr = 5'h00; awvalid = 1'b1; wdata = 32'h5555_5555; wvalid = 1'b1; bready = 1'b0;
        araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_valids", {30'd0, bvalid, rvalid}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valids", {30'd0, bvalid, rvalid}, 32'b00);
        check("mid_rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        axi_write(5'h0C, 32'hCAFE_F00D, 4'hF, r);
        axi_read(5'h0C, d, r);
        check("post_rst_rw", d, 32'hCAFE_F00D);
        check("post_rst_reg0", reg0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
